// File: rtl/fifo_burst_reader.sv
// Read-side master for the fifo block: pops a burst of words and streams them downstream over
// valid/ready, hiding the fifo's one-cycle read latency behind a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_read,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StFlush,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    logic push;
    logic pop;
    logic room;
    logic issue;

    // The word read last cycle appears on fifo_out now and lands in the buffer on this edge.
    assign push = inflight_q;
    assign pop  = (occ_q != 2'd0) && m_ready;

    // Space check counts the in-flight word and credits a same-cycle pop.
    assign room  = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign issue = (state_q == StRead) && !fifo_empty && (issued_q < len_q) && room;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        words_d    = words_q;
        inflight_d = issue;

        if (pop) begin
            words_d = words_q + LEN_W'(1);
        end
        if (issue) begin
            issued_d = issued_q + LEN_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    words_d  = '0;
                    issued_d = '0;
                    if (burst_len != '0) begin
                        len_d   = burst_len;
                        state_d = StRead;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                if (issued_d == len_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (pop && (words_d == len_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Skid buffer: head_q is the downstream register, tail_q holds the second word.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_out;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = fifo_out;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            words_q    <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            words_q    <= words_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign words_read = words_q;
    assign fifo_rd_en = issue;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;

    // A push into a full buffer without a pop would lose a word.
    assert property (@(posedge clk) disable iff (!rst) !(push && !pop && (occ_q == 2'd2)));
    assert property (@(posedge clk) disable iff (!rst) occ_q != 2'd3);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural fifo plus a count-based model of buffered words,
// checking the delivered stream, handshake stability, timing and done/words_read.
module tb_fifo_burst_reader;

    localparam int WIDTH = 10;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_read;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_out = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural fifo: registered out, one pop per rd_en while not empty.
    logic [WIDTH-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .words_read (words_read),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_out   (fifo_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    logic [WIDTH-1:0] obs_q[$];
    int               acc_idx[$];
    int               done_cnt;
    int               done_idx;
    int               first_valid;
    int               base;
    logic             busy_after;

    task automatic push_word(input logic [WIDTH-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic fifo_clear();
        wr_ptr = rd_ptr;
    endtask

    task automatic preload_tens();
        fifo_clear();
        for (int k = 1; k <= 16; k++) push_word(WIDTH'(k * 10));
    endtask

    function automatic logic ready_at(input int mode, input int i);
        logic [5:0] pat;
        pat = 6'b011001;  // 1,0,0,1,1,0 from bit 0 upward
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[i % 6];
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Drives one burst and checks per-cycle invariants against a word-count model:
    // buffered = words read from fifo - words accepted - word still in flight.
    task automatic run_burst(input int len, input int rmode, input int restart_at,
                             input int wr_at, input int wr_n, input int budget);
        int i, acc_before, prev_rd, occ, inflight, pop;
        logic prev_stall;
        logic [WIDTH-1:0] prev_data;
        bit finished;
        obs_q.delete();
        acc_idx.delete();
        done_cnt = 0; done_idx = -1; first_valid = -1; busy_after = 1'bx;
        base = rd_ptr; prev_rd = rd_ptr; acc_before = 0;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1;
        burst_len = LEN_W'(len);
        m_ready = ready_at(rmode, 0);
        i = 0;
        finished = 0;
        while (!finished) begin
            @(negedge clk);
            i++;
            start = (i == restart_at);
            if (i == restart_at) burst_len = LEN_W'(len + 3);
            m_ready = ready_at(rmode, i);
            if (i == wr_at) for (int k = 0; k < wr_n; k++) push_word(WIDTH'($urandom));
            #1;
            inflight = (rd_ptr != prev_rd) ? 1 : 0;
            prev_rd = rd_ptr;
            occ = (rd_ptr - base) - acc_before - inflight;
            pop = (m_valid === 1'b1 && m_ready) ? 1 : 0;
            n_tests += 4;
            if (m_valid !== (occ != 0)) begin
                n_fail++;
                $display("FAIL m_valid cyc %0d: got %b expected %b", i, m_valid, occ != 0);
            end
            if (words_read !== LEN_W'(acc_before)) begin
                n_fail++;
                $display("FAIL words_read cyc %0d: got %0d expected %0d", i, words_read,
                         acc_before);
            end
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: got v=%b d=%0d expected v=1 d=%0d", i,
                         m_valid, m_data, prev_data);
            end
            if (fifo_rd_en === 1'b1 && (occ + inflight - pop >= 2)) begin
                n_fail++;
                $display("FAIL overflow cyc %0d: got rd_en=1 with %0d words held, expected 0",
                         i, occ + inflight);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_idx = i;
            end
            if (m_valid === 1'b1 && first_valid < 0) first_valid = i;
            if (pop != 0) begin
                obs_q.push_back(m_data);
                acc_idx.push_back(i);
                acc_before++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            if (done_idx >= 0 && i == done_idx + 1) begin
                busy_after = busy;
                finished = 1;
            end else if (i >= budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: got no completion in %0d cycles, expected done", budget);
                finished = 1;
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        fifo_clear();
        for (int k = 0; k < 5; k++) push_word(WIDTH'(k + 1));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests += 6;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        if (words_read !== '0) begin
            n_fail++; $display("FAIL rst_words: got %0d expected 0", words_read);
        end
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b expected 0", m_valid);
        end
        if (m_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0d expected 0", m_data); end
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_burst4();
        preload_tens();
        run_burst(4, 0, -1, -1, 0, 60);
        n_tests += 6;
        if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL b4_count: got %0d expected 4", obs_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_tests += 2;
            if (k >= obs_q.size() || obs_q[k] !== WIDTH'(10 * (k + 1))) begin
                n_fail++; $display("FAIL b4_data[%0d]: got %0d expected %0d", k,
                                   (k < obs_q.size()) ? obs_q[k] : 'x, 10 * (k + 1));
            end
            if (k >= acc_idx.size() || acc_idx[k] != 3 + k) begin
                n_fail++; $display("FAIL b4_beat_cycle[%0d]: got %0d expected %0d", k,
                                   (k < acc_idx.size()) ? acc_idx[k] : -1, 3 + k);
            end
        end
        if (first_valid != 3) begin
            n_fail++; $display("FAIL b4_first_valid: got %0d expected 3", first_valid);
        end
        if (done_cnt != 1 || done_idx != 7) begin
            n_fail++; $display("FAIL b4_done: got %0d pulses at %0d expected 1 at 7",
                               done_cnt, done_idx);
        end
        if (words_read !== LEN_W'(4)) begin
            n_fail++; $display("FAIL b4_words: got %0d expected 4", words_read);
        end
        if (busy_after !== 1'b0) begin
            n_fail++; $display("FAIL b4_idle: got busy=%b expected 0", busy_after);
        end
        if (rd_ptr - base != 4 || mem[rd_ptr] !== WIDTH'(50)) begin
            n_fail++; $display("FAIL b4_fifo_left: got %0d reads next %0d expected 4 next 50",
                               rd_ptr - base, mem[rd_ptr]);
        end
    endtask

    task automatic test_ready_toggle();
        preload_tens();
        run_burst(6, 1, -1, -1, 0, 100);
        n_tests += 3;
        if (obs_q.size() != 6) begin
            n_fail++; $display("FAIL tog_count: got %0d expected 6", obs_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (k >= obs_q.size() || obs_q[k] !== WIDTH'(10 * (k + 1))) begin
                n_fail++; $display("FAIL tog_data[%0d]: got %0d expected %0d", k,
                                   (k < obs_q.size()) ? obs_q[k] : 'x, 10 * (k + 1));
            end
        end
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL tog_done: got %0d pulses expected 1", done_cnt);
        end
        if (rd_ptr - base != 6) begin
            n_fail++; $display("FAIL tog_reads: got %0d expected 6", rd_ptr - base);
        end
    endtask

    task automatic test_empty_stall();
        fifo_clear();
        push_word(WIDTH'(100));
        push_word(WIDTH'(200));
        run_burst(5, 0, -1, 10, 3, 100);
        n_tests += 5;
        if (obs_q.size() != 5) begin
            n_fail++; $display("FAIL stall_count: got %0d expected 5", obs_q.size());
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (k >= obs_q.size() || obs_q[k] !== mem[base + k]) begin
                n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", k,
                                   (k < obs_q.size()) ? obs_q[k] : 'x, mem[base + k]);
            end
        end
        if (acc_idx.size() != 5 || acc_idx[1] != 4) begin
            n_fail++; $display("FAIL stall_second_beat: got %0d expected 4",
                               (acc_idx.size() > 1) ? acc_idx[1] : -1);
        end
        if (acc_idx.size() != 5 || acc_idx[2] != 12) begin
            n_fail++; $display("FAIL stall_resume_beat: got %0d expected 12",
                               (acc_idx.size() > 2) ? acc_idx[2] : -1);
        end
        if (done_cnt != 1 || done_idx != 15) begin
            n_fail++; $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 15",
                               done_cnt, done_idx);
        end
        if (rd_ptr - base != 5) begin
            n_fail++; $display("FAIL stall_reads: got %0d expected 5", rd_ptr - base);
        end
    endtask

    task automatic test_zero_len();
        fifo_clear();
        for (int k = 0; k < 3; k++) push_word(WIDTH'(7 * k + 1));
        run_burst(0, 0, -1, -1, 0, 20);
        n_tests += 5;
        if (done_cnt != 1 || done_idx != 1) begin
            n_fail++; $display("FAIL zero_done: got %0d pulses at %0d expected 1 at 1",
                               done_cnt, done_idx);
        end
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL zero_beats: got %0d expected 0", obs_q.size());
        end
        if (rd_ptr != base) begin
            n_fail++; $display("FAIL zero_reads: got %0d expected 0", rd_ptr - base);
        end
        if (words_read !== '0) begin
            n_fail++; $display("FAIL zero_words: got %0d expected 0", words_read);
        end
        if (busy_after !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle: got busy=%b expected 0", busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int acc, i;
        preload_tens();
        @(negedge clk);
        start = 1'b1;
        burst_len = LEN_W'(8);
        m_ready = 1'b1;
        acc = 0;
        i = 0;
        while (acc < 3 && i < 50) begin
            @(negedge clk);
            i++;
            start = 1'b0;
            #1;
            if (m_valid === 1'b1 && m_ready) acc++;
        end
        n_tests += 5;
        if (acc < 3) begin
            n_fail++; $display("FAIL midrst_wait: got %0d accepts expected 3", acc);
        end
        @(posedge clk);
        #2;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy);
        end
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b expected 0", m_valid);
        end
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rd_en: got %b expected 0", fifo_rd_en);
        end
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b0;
        run_burst(2, 0, -1, -1, 0, 40);
        n_tests += 2;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (k >= obs_q.size() || obs_q[k] !== mem[base + k]) begin
                n_fail++; $display("FAIL midrst_data[%0d]: got %0d expected %0d", k,
                                   (k < obs_q.size()) ? obs_q[k] : 'x, mem[base + k]);
            end
        end
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL midrst_done: got %0d pulses expected 1", done_cnt);
        end
        if (rd_ptr - base != 2) begin
            n_fail++; $display("FAIL midrst_reads: got %0d expected 2", rd_ptr - base);
        end
    endtask

    task automatic test_restart();
        preload_tens();
        run_burst(4, 0, 2, -1, 0, 60);
        n_tests += 3;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= obs_q.size() || obs_q[k] !== WIDTH'(10 * (k + 1))) begin
                n_fail++; $display("FAIL restart_data[%0d]: got %0d expected %0d", k,
                                   (k < obs_q.size()) ? obs_q[k] : 'x, 10 * (k + 1));
            end
        end
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL restart_done: got %0d pulses expected 1", done_cnt);
        end
        if (rd_ptr - base != 4 || obs_q.size() != 4) begin
            n_fail++; $display("FAIL restart_reads: got %0d reads %0d beats expected 4",
                               rd_ptr - base, obs_q.size());
        end
        if (words_read !== LEN_W'(4)) begin
            n_fail++; $display("FAIL restart_words: got %0d expected 4", words_read);
        end
    endtask

    task automatic test_random();
        int len, pre, wr_at, wr_n;
        for (int it = 0; it < 8; it++) begin
            len   = $urandom_range(1, 31);
            pre   = $urandom_range(0, len);
            wr_at = $urandom_range(2, 25);
            wr_n  = len - pre + $urandom_range(0, 2);
            fifo_clear();
            for (int k = 0; k < pre; k++) push_word(WIDTH'($urandom));
            run_burst(len, 2, -1, wr_at, wr_n, 600);
            n_tests += 3;
            if (obs_q.size() != len) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", it,
                                   obs_q.size(), len);
            end
            for (int k = 0; k < len; k++) begin
                n_tests++;
                if (k >= obs_q.size() || obs_q[k] !== mem[base + k]) begin
                    n_fail++; $display("FAIL rnd%0d_data[%0d]: got %0d expected %0d", it, k,
                                       (k < obs_q.size()) ? obs_q[k] : 'x, mem[base + k]);
                end
            end
            if (done_cnt != 1) begin
                n_fail++; $display("FAIL rnd%0d_done: got %0d pulses expected 1", it, done_cnt);
            end
            if (rd_ptr - base != len) begin
                n_fail++; $display("FAIL rnd%0d_reads: got %0d expected %0d", it,
                                   rd_ptr - base, len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst4();
        test_ready_toggle();
        test_empty_stall();
        test_zero_len();
        test_reset_mid();
        test_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
